uart_dec: RTL and testbench
===========================

# uart_dec

Receive-side command decoder for the UART control path. Takes bytes from the UART receiver as a one-cycle strobe plus data, parses ASCII command lines of the form `W<addr hex><data hex><LF>` or `R<addr hex><LF>`, and presents each complete command as a one-cycle pulse with registered operands. It is the inbound counterpart of the outbound ASCII encoder and feeds the UART controller.

## Interface
- `ADDR_DIGITS`, default 2: hex digits per address; address width AW = 4*ADDR_DIGITS.
- `DATA_DIGITS`, default 1: hex digits per write datum; data width DW = 4*DATA_DIGITS.
- `TIMEOUT_CYC`, default 10_000_000: idle cycles allowed between bytes inside a line (100 ms at 100 MHz).

- `CLK_100M` in 1: clock. One clock domain only.
- `SYS_RST` in 1: synchronous, active-high reset.
- `UART_RX_VALID` in 1: one-cycle strobe, byte available.
- `UART_RX_DATA` in 8: received byte, sampled when `UART_RX_VALID`=1.
- `UART_DEC_CMD_VALID` out 1: one-cycle pulse, command committed.
- `UART_DEC_OP` out 1: 1=write, 0=read.
- `UART_DEC_ADDR` out AW: command address.
- `UART_DEC_WDATA` out DW: write datum.
- `UART_DEC_ERR` out 1: one-cycle pulse, malformed line or timeout.
- `UART_DEC_BUSY` out 1: high while a line is partially received.

## Operation
- Hex digits: '0'-'9' map to 0-9; 'A'-'F' and 'a'-'f' map to 10-15. All other bytes are non-hex.
- 0x0D is ignored in every state. 0x0A (LF) terminates a line.
- FSM states: IDLE, ADDR, DATA, EOL, FLUSH.
  - IDLE: 'W'/'w' sets op=1 and goes to ADDR. 'R'/'r' sets op=0 and goes to ADDR. LF stays in IDLE with no pulse. Any other byte goes to FLUSH.
  - ADDR: each hex digit shifts in MSB-first, `addr_sh <= {addr_sh[AW-5:0], nib}`. After ADDR_DIGITS digits, go to DATA if op=1, else EOL.
  - DATA: same shifting into `data_sh`. After DATA_DIGITS digits, go to EOL.
  - EOL: LF commits the command and returns to IDLE. Any other byte goes to FLUSH.
  - FLUSH: discard bytes until LF, then pulse ERR and return to IDLE.
- In ADDR or DATA, a non-hex byte goes to FLUSH. If that byte is LF, pulse ERR immediately and return to IDLE.
- Commit: copy the shift registers and op into the output registers and pulse CMD_VALID. For a read, `UART_DEC_WDATA` keeps its previous value.
- Output registers change only on commit or reset. Errors never modify ADDR, WDATA or OP.
- Timeout:
  - The counter clears on every `UART_RX_VALID` and while in IDLE.
  - Outside IDLE, if TIMEOUT_CYC consecutive cycles pass without a byte, pulse ERR and go to IDLE, discarding partial state.
- `UART_DEC_BUSY` = (state != IDLE), registered from the state.

## Timing
- Reset (synchronous): state=IDLE, counter=0, all outputs 0.
- Latency: CMD_VALID and ERR go high in the cycle after the clock edge that samples the terminating LF (or the timeout expiry), for exactly one cycle.
- CMD_VALID and ERR are never high in the same cycle.
- A byte strobe in the same cycle as timeout expiry: the byte wins. The counter clears and the byte is processed, with no ERR.
- A byte strobe in the cycle where CMD_VALID or ERR is high is processed normally from IDLE.
- Back-to-back strobes on consecutive cycles must be accepted. There is no backpressure.
- Reset mid-line drops the partial command. The next byte is interpreted from IDLE.
- Counter width: $clog2(TIMEOUT_CYC+1). It saturates and does not wrap.
- Digit counter width: $clog2(max(ADDR_DIGITS, DATA_DIGITS)+1). It reloads to 0 on every state change.

## Structure
- Shared package `uart_pkg`:
  - ASCII constants used by both directions (LF, CR, 'W', 'w', 'R', 'r', and the existing O/K/F/A/I/L/'>').
  - The FSM state enum.
  - Op encoding constants.
- Sub-module `uart_hex_nib`: combinational byte to {is_hex, nib[3:0]} decoder. It is reusable by other ASCII parsers.
- Top level: FSM, shift registers, digit counter, timeout counter, output registers.

## Test plan
- "W3A7\n" → one cycle after the LF: CMD_VALID=1, OP=1, ADDR=0x3A, WDATA=0x7, ERR=0. BUSY is high from 'W' through the LF.
- Then "r0f\r\n" → CMD_VALID=1, OP=0, ADDR=0x0F, WDATA stays 0x7.
- "W3G7\n" → no CMD_VALID. ERR pulses one cycle after the LF. ADDR/WDATA/OP are unchanged. "\n" alone → no pulse of either kind.
- "W3" then TIMEOUT_CYC idle cycles (bench override TIMEOUT_CYC=16) → ERR pulses once and BUSY drops. A following "R12\n" gives ADDR=0x12. A byte arriving exactly at expiry gives no ERR.
- "W3", then SYS_RST for 1 cycle, then "A7\n" → all outputs 0 after reset. 'A' sends the FSM to FLUSH and ERR pulses at the LF, with no CMD_VALID.
- Back-to-back strobes "W","F","F","F","\n" on consecutive cycles → ADDR=0xFF, WDATA=0xF. "W3A7Z\n" → ERR.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the ASCII UART control path: character codes,
// decoder FSM states and op encoding.
package uart_pkg;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_W_LC  = 8'h77;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_R_LC  = 8'h72;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_L     = 8'h4C;
  localparam logic [7:0] CH_PROMPT = 8'h3E;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOL   = 3'd3,
    ST_FLUSH = 3'd4
  } dec_state_e;

endpackage

// File: rtl/uart_hex_nib.sv
// ASCII byte to hex nibble decoder; accepts 0-9, A-F and a-f.
module uart_hex_nib (
  input  logic [7:0] byte_i,
  output logic       is_hex_o,
  output logic [3:0] nib_o
);

  // Letters 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
  always_comb begin
    is_hex_o = 1'b0;
    nib_o    = byte_i[3:0];
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      is_hex_o = 1'b1;
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      is_hex_o = 1'b1;
      nib_o    = byte_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_dec.sv
// Receive-side ASCII command decoder: parses W<addr><data>LF / R<addr>LF lines
// into one-cycle command pulses with registered operands.
module uart_dec
  import uart_pkg::*;
#(
  parameter int ADDR_DIGITS = 2,
  parameter int DATA_DIGITS = 1,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic                       CLK_100M,
  input  logic                       SYS_RST,
  input  logic                       UART_RX_VALID,
  input  logic [7:0]                 UART_RX_DATA,
  output logic                       UART_DEC_CMD_VALID,
  output logic                       UART_DEC_OP,
  output logic [4*ADDR_DIGITS-1:0]   UART_DEC_ADDR,
  output logic [4*DATA_DIGITS-1:0]   UART_DEC_WDATA,
  output logic                       UART_DEC_ERR,
  output logic                       UART_DEC_BUSY
);

  localparam int AW    = 4 * ADDR_DIGITS;
  localparam int DW    = 4 * DATA_DIGITS;
  localparam int MAXD  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int DCW   = $clog2(MAXD + 1);
  localparam int TMW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DCW-1:0] ADDR_LAST = DCW'(ADDR_DIGITS - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_DIGITS - 1);
  localparam logic [TMW-1:0] TMO_LAST  = TMW'(TIMEOUT_CYC - 1);
  localparam logic [TMW-1:0] TMO_MAX   = TMW'(TIMEOUT_CYC);

  dec_state_e     state_q, state_d;
  logic [DCW-1:0] dig_q, dig_d;
  logic [TMW-1:0] tmo_q, tmo_d;
  logic [AW-1:0]  addr_sh_q, addr_sh_d;
  logic [DW-1:0]  data_sh_q, data_sh_d;
  logic           op_sh_q, op_sh_d;
  logic           cmd_valid_q, err_q, op_q, busy_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic           commit, err_d, tmo_expire;
  logic           is_hex;
  logic [3:0]     nib;
  logic [AW+3:0]  addr_ext;
  logic [DW+3:0]  data_ext;

  uart_hex_nib u_hex (
    .byte_i   (UART_RX_DATA),
    .is_hex_o (is_hex),
    .nib_o    (nib)
  );

  assign addr_ext = {addr_sh_q, nib};
  assign data_ext = {data_sh_q, nib};

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    op_sh_d    = op_sh_q;
    commit     = 1'b0;
    err_d      = 1'b0;
    tmo_expire = (state_q != ST_IDLE) && !UART_RX_VALID && (tmo_q >= TMO_LAST);

    if (UART_RX_VALID && UART_RX_DATA != CH_CR) begin
      unique case (state_q)
        ST_IDLE: begin
          if (UART_RX_DATA == CH_W || UART_RX_DATA == CH_W_LC) begin
            op_sh_d = OP_WRITE;
            state_d = ST_ADDR;
          end else if (UART_RX_DATA == CH_R || UART_RX_DATA == CH_R_LC) begin
            op_sh_d = OP_READ;
            state_d = ST_ADDR;
          end else if (UART_RX_DATA != CH_LF) begin
            state_d = ST_FLUSH;
          end
        end
        ST_ADDR: begin
          if (is_hex) begin
            addr_sh_d = addr_ext[AW-1:0];
            if (dig_q == ADDR_LAST) state_d = (op_sh_q == OP_WRITE) ? ST_DATA : ST_EOL;
            else                    dig_d   = dig_q + 1'b1;
          end else if (UART_RX_DATA == CH_LF) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_DATA: begin
          if (is_hex) begin
            data_sh_d = data_ext[DW-1:0];
            if (dig_q == DATA_LAST) state_d = ST_EOL;
            else                    dig_d   = dig_q + 1'b1;
          end else if (UART_RX_DATA == CH_LF) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_EOL: begin
          if (UART_RX_DATA == CH_LF) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (UART_RX_DATA == CH_LF) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    if (state_d != state_q) dig_d = '0;

    // Counter only runs while a line is open and no byte arrives; it saturates.
    if (UART_RX_VALID || state_q == ST_IDLE || tmo_expire) tmo_d = '0;
    else if (tmo_q != TMO_MAX)                             tmo_d = tmo_q + 1'b1;
    else                                                   tmo_d = tmo_q;
  end

  always_ff @(posedge CLK_100M) begin
    if (SYS_RST) begin
      state_q     <= ST_IDLE;
      dig_q       <= '0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= commit;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
      if (commit) begin
        op_q   <= op_sh_q;
        addr_q <= addr_sh_q;
        if (op_sh_q == OP_WRITE) wdata_q <= data_sh_q;
      end
    end
  end

  always_ff @(posedge CLK_100M) begin
    addr_sh_q <= addr_sh_d;
    data_sh_q <= data_sh_d;
    op_sh_q   <= op_sh_d;
  end

  assign UART_DEC_CMD_VALID = cmd_valid_q;
  assign UART_DEC_ERR       = err_q;
  assign UART_DEC_BUSY      = busy_q;
  assign UART_DEC_OP        = op_q;
  assign UART_DEC_ADDR      = addr_q;
  assign UART_DEC_WDATA     = wdata_q;

endmodule

// File: tb/tb_uart_dec.sv
// Randomized line-level bench for uart_dec with a text-level reference model.
module tb_uart_dec;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_valid, op, err, busy;
  logic [7:0] addr;
  logic [3:0] wdata;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  uart_dec #(.ADDR_DIGITS(2), .DATA_DIGITS(1), .TIMEOUT_CYC(TMO)) dut (
    .CLK_100M           (clk),
    .SYS_RST            (rst),
    .UART_RX_VALID      (rx_valid),
    .UART_RX_DATA       (rx_data),
    .UART_DEC_CMD_VALID (cmd_valid),
    .UART_DEC_OP        (op),
    .UART_DEC_ADDR      (addr),
    .UART_DEC_WDATA     (wdata),
    .UART_DEC_ERR       (err),
    .UART_DEC_BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - 8'h30);
    if (c >= "A" && c <= "F") return 4'(c - 8'h41 + 8'd10);
    return 4'(c - 8'h61 + 8'd10);
  endfunction

  // Reference model: collect the line text, judge it as a whole at LF.
  logic [7:0] line[$];
  int   idle = 0;
  logic m_cmd = 0, m_err = 0, m_op = 0, m_busy = 0;
  logic [7:0] m_addr = 0;
  logic [3:0] m_wdata = 0;

  always @(posedge clk) begin
    m_cmd = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      line.delete();
      idle = 0; m_op = 0; m_addr = 0; m_wdata = 0;
    end else if (rx_valid) begin
      idle = 0;
      if (rx_data == 8'h0A) begin
        if (line.size() > 0) begin
          if ((line[0] == "W" || line[0] == "w") && line.size() == 4 &&
              is_hex(line[1]) && is_hex(line[2]) && is_hex(line[3])) begin
            m_cmd = 1; m_op = 1;
            m_addr = {hexval(line[1]), hexval(line[2])};
            m_wdata = hexval(line[3]);
          end else if ((line[0] == "R" || line[0] == "r") && line.size() == 3 &&
                       is_hex(line[1]) && is_hex(line[2])) begin
            m_cmd = 1; m_op = 0;
            m_addr = {hexval(line[1]), hexval(line[2])};
          end else begin
            m_err = 1;
          end
        end
        line.delete();
      end else if (rx_data != 8'h0D) begin
        line.push_back(rx_data);
      end
    end else if (line.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        m_err = 1;
        line.delete();
        idle = 0;
      end
    end
    m_busy = (line.size() > 0);
    #1;
    if (chk_en) begin
      chk("cmd_valid", 32'(cmd_valid), 32'(m_cmd));
      chk("err",       32'(err),       32'(m_err));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("op",        32'(op),        32'(m_op));
      chk("addr",      32'(addr),      32'(m_addr));
      chk("wdata",     32'(wdata),     32'(m_wdata));
    end
  end

  // All stimulus tasks start and end on a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  string hexs = "0123456789abcdefABCDEF";
  string junk = "WwRrGZ x0F9";

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, gap, k;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_cmd", 32'(cmd_valid), 0);
    chk("rst_addr", 32'(addr), 0);

    send_str("W3A7\n");
    chk("w3a7_cmd", 32'(cmd_valid), 1);
    chk("w3a7_op", 32'(op), 1);
    chk("w3a7_addr", 32'(addr), 32'h3A);
    chk("w3a7_wdata", 32'(wdata), 32'h7);

    send_str("r0f");
    send_byte(8'h0D, 0);
    send_str("\n");
    chk("r0f_cmd", 32'(cmd_valid), 1);
    chk("r0f_op", 32'(op), 0);
    chk("r0f_addr", 32'(addr), 32'h0F);
    chk("r0f_wdata", 32'(wdata), 32'h7);

    send_str("W3G7\n");
    chk("w3g7_err", 32'(err), 1);
    chk("w3g7_cmd", 32'(cmd_valid), 0);
    chk("w3g7_addr", 32'(addr), 32'h0F);
    send_str("\n");
    chk("lf_err", 32'(err), 0);

    send_str("W3");
    idle_cyc(TMO);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_busy", 32'(busy), 0);
    send_str("R12\n");
    chk("r12_addr", 32'(addr), 32'h12);

    send_str("W3");
    idle_cyc(TMO - 1);
    send_str("A7\n");
    chk("edge_cmd", 32'(cmd_valid), 1);
    chk("edge_addr", 32'(addr), 32'h3A);

    send_str("W3");
    pulse_reset();
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    send_str("A7\n");
    chk("after_rst_err", 32'(err), 1);

    send_str("WFFF\n");
    chk("b2b_addr", 32'(addr), 32'hFF);
    chk("b2b_wdata", 32'(wdata), 32'hF);
    send_str("W3A7Z\n");
    chk("extra_err", 32'(err), 1);

    for (int n = 0; n < 400; n++) begin
      line_q_build(kind);
      for (int i = 0; i < lq.size(); i++) begin
        k = $urandom_range(0, 39);
        if (k < 28)      gap = 0;
        else if (k < 36) gap = $urandom_range(1, 3);
        else if (k < 38) gap = TMO - 1;
        else             gap = $urandom_range(TMO, TMO + 2);
        if ($urandom_range(0, 199) == 0) pulse_reset();
        send_byte(lq[i], gap);
      end
      idle_cyc($urandom_range(0, 2));
    end
    idle_cyc(TMO + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  logic [7:0] lq[$];

  task automatic line_q_build(output int kind);
    int len;
    lq.delete();
    kind = $urandom_range(0, 9);
    if (kind <= 5 || kind == 8) begin
      k_pick_cmd();
      if (kind == 8) lq.insert($urandom_range(0, lq.size()), 8'h0D);
    end else if (kind == 6) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) lq.push_back(junk[$urandom_range(0, junk.len() - 1)]);
    end else if (kind == 9) begin
      k_pick_cmd();
      lq = lq[0:$urandom_range(0, lq.size() - 1)];
      return;
    end
    lq.push_back(8'h0A);
  endtask

  task automatic k_pick_cmd();
    int c;
    c = $urandom_range(0, 3);
    lq.push_back(c == 0 ? 8'h57 : c == 1 ? 8'h77 : c == 2 ? 8'h52 : 8'h72);
    lq.push_back(hexs[$urandom_range(0, hexs.len() - 1)]);
    lq.push_back(hexs[$urandom_range(0, hexs.len() - 1)]);
    if (c < 2) lq.push_back(hexs[$urandom_range(0, hexs.len() - 1)]);
  endtask

endmodule
